pp_column_loader: RTL and testbench

Bit-serial operand loader and partial-product column generator for the W×W multiplier compressor test path. It sits directly upstream of `compressor`. It shifts in two W-bit operands one bit per accepted beat, LSB first. It then presents the AND-array partial products as registered column vectors `src0`..`src(2W-2)` under a valid/ready handshake. It replaces free-running per-column shift registers with a framed, operand-accurate stimulus source.

---
 rtl/pp_column_loader_if.sv | 25 ++
 rtl/pp_column_loader.sv | 99 +++++++++
 tb/tb_pp_column_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pp_column_loader_if.sv
// rtl/pp_column_loader_if.sv - serial operand beat stream in, partial-product column frame out.
// cols packs column k at bit offset sum(width of columns 0..k-1); total width is W*W.
interface pp_column_loader_if #(
    parameter int W = 20
);
    localparam int NB = W * W;

    logic          in_valid;
    logic          in_ready;
    logic          a_bit;
    logic          b_bit;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] cols;

    modport slave (
        input  in_valid, a_bit, b_bit, out_ready,
        output in_ready, out_valid, cols
    );

    modport master (
        output in_valid, a_bit, b_bit, out_ready,
        input  in_ready, out_valid, cols
    );
endinterface

// File: rtl/pp_column_loader.sv
// rtl/pp_column_loader.sv - bit-serial operand loader and AND-array partial-product column generator.
// Shifts in W-bit A/B LSB first, then holds registered columns src0..src(2W-2) under valid/ready.
module pp_column_loader #(
    parameter int W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pp_column_loader_if.slave    io
);
    localparam int NB = W * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    function automatic int col_w(input int k);
        return ((k < 2*W-2-k) ? k : 2*W-2-k) + 1;
    endfunction

    function automatic int col_off(input int k);
        int s;
        s = 0;
        for (int m = 0; m < k; m++) s += col_w(m);
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [NB-1:0] cols_q, cols_d;
    logic [W-1:0]  a_new, b_new;
    logic [NB-1:0] pp;

    assign a_new = {io.a_bit, a_q[W-1:1]};
    assign b_new = {io.b_bit, b_q[W-1:1]};

    // Columns are formed from the post-shift operands so the completing beat lands in the frame.
    for (genvar k = 0; k < 2*W-1; k++) begin : g_col
        for (genvar j = 0; j < col_w(k); j++) begin : g_bit
            localparam int I = j + ((k > W-1) ? (k - W + 1) : 0);
            assign pp[col_off(k) + j] = a_new[I] & b_new[k - I];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cols_d  = cols_q;
        if (flush) begin
            state_d = S_LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (io.in_valid) begin
                        a_d = a_new;
                        b_d = b_new;
                        if (cnt_q == CW'(W-1)) begin
                            cnt_d   = '0;
                            cols_d  = pp;
                            state_d = S_HOLD;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (io.out_ready) state_d = S_LOAD;
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cols_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cols_q  <= cols_d;
        end
    end

    assign io.in_ready  = (state_q == S_LOAD);
    assign io.out_valid = (state_q == S_HOLD);
    assign io.cols      = cols_q;
endmodule

// File: tb/tb_pp_column_loader.sv
// tb/tb_pp_column_loader.sv - table-driven and sequence checks for pp_column_loader.
module tb_pp_column_loader;
    localparam int W  = 20;
    localparam int NB = W * W;

    logic clk;
    logic rst_n;
    logic flush;

    pp_column_loader_if #(.W(W)) io ();

    pp_column_loader #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           gap;
        logic [63:0]  prod;
        int           k0;
        logic [W-1:0] c0;
        int           k1;
        logic [W-1:0] c1;
    } vec_t;

    vec_t vecs [7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int cw(input int k);
        return ((k < 2*W-2-k) ? k : 2*W-2-k) + 1;
    endfunction

    function automatic logic [W-1:0] col(input int k);
        int o;
        logic [W-1:0] c;
        o = 0;
        c = '0;
        for (int m = 0; m < k; m++) o += cw(m);
        for (int j = 0; j < cw(k); j++) c[j] = io.cols[o + j];
        return c;
    endfunction

    function automatic logic [63:0] wsum();
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < 2*W-1; k++) s += 64'($countones(col(k))) << k;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input bit gap);
        for (int i = 0; i < W; i++) begin
            if (gap && (i % 2 == 1)) begin
                io.in_valid = 1'b0;
                step();
            end
            io.in_valid = 1'b1;
            io.a_bit    = a[i];
            io.b_bit    = b[i];
            if (i == W-1) chk("early_valid", 64'(io.out_valid), 64'd0);
            step();
        end
        io.in_valid = 1'b0;
    endtask

    task automatic check_frame(input logic [63:0] prod, input int k0, input logic [W-1:0] c0,
                               input int k1, input logic [W-1:0] c1);
        chk("out_valid_hold", 64'(io.out_valid), 64'd1);
        chk("in_ready_hold", 64'(io.in_ready), 64'd0);
        chk("weighted_sum", wsum(), prod);
        chk($sformatf("src%0d", k0), 64'(col(k0)), 64'(c0));
        chk($sformatf("src%0d", k1), 64'(col(k1)), 64'(c1));
    endtask

    initial begin
        vecs[0] = '{a: 20'h00001, b: 20'h00001, gap: 0, prod: 64'h1,          k0: 0,  c0: 20'h1,     k1: 1,  c1: 20'h0};
        vecs[1] = '{a: 20'h00003, b: 20'h00005, gap: 0, prod: 64'hF,          k0: 1,  c0: 20'h2,     k1: 3,  c1: 20'h2};
        vecs[2] = '{a: 20'hFFFFF, b: 20'hFFFFF, gap: 0, prod: 64'hFFFFE00001, k0: 19, c0: 20'hFFFFF, k1: 38, c1: 20'h1};
        vecs[3] = '{a: 20'h80000, b: 20'h80000, gap: 1, prod: 64'h4000000000, k0: 38, c0: 20'h1,     k1: 19, c1: 20'h0};
        vecs[4] = '{a: 20'h00002, b: 20'h00002, gap: 0, prod: 64'h4,          k0: 2,  c0: 20'h2,     k1: 1,  c1: 20'h0};
        vecs[5] = '{a: 20'hFFFFF, b: 20'h00001, gap: 0, prod: 64'hFFFFF,      k0: 19, c0: 20'h80000, k1: 0,  c1: 20'h1};
        vecs[6] = '{a: 20'h00400, b: 20'h00200, gap: 1, prod: 64'h80000,      k0: 19, c0: 20'h00400, k1: 20, c1: 20'h0};

        rst_n        = 1'b0;
        flush        = 1'b0;
        io.in_valid  = 1'b0;
        io.a_bit     = 1'b0;
        io.b_bit     = 1'b0;
        io.out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 64'(io.in_ready), 64'd1);
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_cols_zero", 64'(io.cols == '0), 64'd1);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 7; v++) begin
            load(vecs[v].a, vecs[v].b, vecs[v].gap);
            check_frame(vecs[v].prod, vecs[v].k0, vecs[v].c0, vecs[v].k1, vecs[v].c1);
            step();
            chk("out_valid_one_cycle", 64'(io.out_valid), 64'd0);
            chk("in_ready_after", 64'(io.in_ready), 64'd1);
        end

        // Backpressure: frame held, beats during HOLD must be ignored.
        io.out_ready = 1'b0;
        load(20'hFFFFF, 20'hFFFFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            io.in_valid = c[0];
            io.a_bit    = 1'b0;
            io.b_bit    = 1'b0;
            chk("bp_out_valid", 64'(io.out_valid), 64'd1);
            chk("bp_in_ready", 64'(io.in_ready), 64'd0);
            step();
        end
        io.in_valid = 1'b0;
        chk("bp_src19_stable", 64'(col(19)), 64'hFFFFF);
        chk("bp_src38_stable", 64'(col(38)), 64'h1);
        io.out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(io.out_valid), 64'd0);
        load(20'h00001, 20'h00001, 1'b0);
        check_frame(64'h1, 0, 20'h1, 19, 20'h0);
        step();

        // Flush mid-load: aborted frame never appears, counter restarts.
        for (int i = 0; i < 10; i++) begin
            io.in_valid = 1'b1;
            io.a_bit    = 1'b1;
            io.b_bit    = 1'b1;
            step();
        end
        flush = 1'b1;
        step();
        flush       = 1'b0;
        io.in_valid = 1'b0;
        chk("flush_out_valid", 64'(io.out_valid), 64'd0);
        chk("flush_in_ready", 64'(io.in_ready), 64'd1);
        chk("flush_cols_kept", 64'(col(0)), 64'h1);
        load(20'h00002, 20'h00002, 1'b0);
        check_frame(64'h4, 2, 20'h2, 0, 20'h0);
        step();

        // Asynchronous reset during HOLD.
        io.out_ready = 1'b0;
        load(20'hFFFFF, 20'hFFFFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(io.out_valid), 64'd0);
        chk("arst_in_ready", 64'(io.in_ready), 64'd1);
        chk("arst_cols_zero", 64'(io.cols == '0), 64'd1);
        @(negedge clk);
        rst_n        = 1'b1;
        io.out_ready = 1'b1;
        step();
        load(20'h00003, 20'h00005, 1'b0);
        check_frame(64'hF, 2, 20'h1, 3, 20'h2);
        step();
        chk("arst_final_valid", 64'(io.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
